// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and execute.
//
// Each accepted word is split into R, J or I fields and registered together
// with its raw word and PC. A one-entry skid register catches the word that
// arrives while the output register is stalled. Because of it, in_ready is
// simply ~sk_valid & ~flush.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             drop the held words and refuse input this cycle
//   in_valid/in_ready fetch-side handshake, in_instr/in_pc payload
//   out_valid/out_ready execute-side handshake
//   out_kind          00 R, 01 J, 10 I, 11 illegal
//   out_opcode, out_rd/rs/rt, out_func, out_imm, out_offset  decoded fields
//   out_instr, out_pc raw word and address
//   decode_count      output transfers, modulo 2^16
module decode_stage #(
  parameter int OP_W     = 4,
  parameter int REG_W    = 3,
  parameter int FUNC_W   = 3,
  parameter int DATA_W   = 16,
  parameter int PC_W     = 16,
  parameter int R_OPCODE = 0,
  parameter int J_OPCODE = 1,
  parameter int OP_LIMIT = 12,
  localparam int INSTR_W = OP_W + 3*REG_W + FUNC_W,
  localparam int OFF_W   = INSTR_W - OP_W - FUNC_W,
  localparam int IMM_W   = INSTR_W - OP_W - 2*REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_kind,
  output logic [OP_W-1:0]    out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [FUNC_W-1:0]  out_func,
  output logic [DATA_W-1:0]  out_imm,
  output logic [DATA_W-1:0]  out_offset,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [15:0]        decode_count
);

  localparam logic [1:0] K_R   = 2'd0;
  localparam logic [1:0] K_J   = 2'd1;
  localparam logic [1:0] K_I   = 2'd2;
  localparam logic [1:0] K_ILL = 2'd3;

  localparam logic [OP_W-1:0] R_OP   = OP_W'(R_OPCODE);
  localparam logic [OP_W-1:0] J_OP   = OP_W'(J_OPCODE);
  // One extra bit so that OP_LIMIT == 2**OP_W, meaning nothing is illegal,
  // still compares correctly.
  localparam logic [OP_W:0]   OP_LIM = (OP_W+1)'(OP_LIMIT);

  // MSB of the field area just below the opcode.
  localparam int F_HI = INSTR_W - OP_W - 1;

  typedef struct packed {
    logic [1:0]         kind;
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [FUNC_W-1:0]  func;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  offset;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } dec_t;

  logic               sk_valid;
  logic [INSTR_W-1:0] sk_instr;
  logic [PC_W-1:0]    sk_pc;
  logic [INSTR_W-1:0] src_instr;
  logic [PC_W-1:0]    src_pc;
  dec_t               dec;
  dec_t               dout;

  logic in_fire, out_fire, or_free;

  assign in_ready = ~sk_valid & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign or_free  = ~out_valid | out_fire;

  // The skid entry is older than anything on the input, so it decodes first.
  assign src_instr = sk_valid ? sk_instr : in_instr;
  assign src_pc    = sk_valid ? sk_pc    : in_pc;

  always_comb begin
    dec        = '0;
    dec.instr  = src_instr;
    dec.pc     = src_pc;
    dec.opcode = src_instr[INSTR_W-1 -: OP_W];
    if ({1'b0, dec.opcode} >= OP_LIM) begin
      dec.kind = K_ILL;
    end else if (dec.opcode == R_OP) begin
      dec.kind = K_R;
      dec.rd   = src_instr[F_HI -: REG_W];
      dec.rs   = src_instr[F_HI-REG_W -: REG_W];
      dec.rt   = src_instr[F_HI-2*REG_W -: REG_W];
      dec.func = src_instr[FUNC_W-1:0];
    end else if (dec.opcode == J_OP) begin
      dec.kind   = K_J;
      dec.offset = DATA_W'($signed(src_instr[FUNC_W +: OFF_W]));
      dec.func   = src_instr[FUNC_W-1:0];
    end else begin
      dec.kind = K_I;
      dec.rs   = src_instr[F_HI -: REG_W];
      dec.rt   = src_instr[F_HI-REG_W -: REG_W];
      dec.imm  = DATA_W'($signed(src_instr[IMM_W-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      sk_valid     <= 1'b0;
      sk_instr     <= '0;
      sk_pc        <= '0;
      dout         <= '0;
      decode_count <= '0;
    end else begin
      // A transfer in a flush cycle has already been seen by execute.
      if (out_fire) decode_count <= decode_count + 16'd1;
      if (flush) begin
        out_valid <= 1'b0;
        sk_valid  <= 1'b0;
      end else if (or_free) begin
        if (sk_valid) begin
          // in_ready is low here, so no input is lost.
          dout      <= dec;
          out_valid <= 1'b1;
          sk_valid  <= 1'b0;
        end else if (in_fire) begin
          dout      <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        sk_instr <= in_instr;
        sk_pc    <= in_pc;
        sk_valid <= 1'b1;
      end
    end
  end

  assign out_kind   = dout.kind;
  assign out_opcode = dout.opcode;
  assign out_rd     = dout.rd;
  assign out_rs     = dout.rs;
  assign out_rt     = dout.rt;
  assign out_func   = dout.func;
  assign out_imm    = dout.imm;
  assign out_offset = dout.offset;
  assign out_instr  = dout.instr;
  assign out_pc     = dout.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of hand-decoded words streamed back to back,
// directed backpressure / flush / illegal / reset sequences, a randomized
// run against a queue of independently decoded words, and counter wrap.
module tb_decode_stage;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [1:0]  kind;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt, func;
    logic [15:0] imm, off;
  } vec_t;

  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr, in_pc, out_imm, out_offset, out_instr, out_pc, decode_count;
  logic [1:0]  out_kind;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs, out_rt, out_func;

  int n_chk = 0;
  int n_fail = 0;

  vec_t vt[NV];
  vec_t q[$];
  vec_t e;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_func(out_func), .out_imm(out_imm), .out_offset(out_offset),
    .out_instr(out_instr), .out_pc(out_pc), .decode_count(decode_count)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string nm, input vec_t x);
    chk({nm, ".valid"},  32'(out_valid),  32'd1);
    chk({nm, ".kind"},   32'(out_kind),   32'(x.kind));
    chk({nm, ".opcode"}, 32'(out_opcode), 32'(x.op));
    chk({nm, ".rd"},     32'(out_rd),     32'(x.rd));
    chk({nm, ".rs"},     32'(out_rs),     32'(x.rs));
    chk({nm, ".rt"},     32'(out_rt),     32'(x.rt));
    chk({nm, ".func"},   32'(out_func),   32'(x.func));
    chk({nm, ".imm"},    32'(out_imm),    32'(x.imm));
    chk({nm, ".offset"}, 32'(out_offset), 32'(x.off));
    chk({nm, ".instr"},  32'(out_instr),  32'(x.instr));
    chk({nm, ".pc"},     32'(out_pc),     32'(x.pc));
  endtask

  // Reference decode written with fixed bit positions for the default widths.
  function automatic vec_t model(input logic [15:0] i, input logic [15:0] p);
    vec_t v;
    v = '{instr: i, pc: p, kind: 2'd0, op: i[15:12], rd: 3'd0, rs: 3'd0, rt: 3'd0,
          func: 3'd0, imm: 16'd0, off: 16'd0};
    if (i[15:12] >= 4'd12) begin
      v.kind = 2'd3;
    end else if (i[15:12] == 4'd0) begin
      v.rd = i[11:9]; v.rs = i[8:6]; v.rt = i[5:3]; v.func = i[2:0];
    end else if (i[15:12] == 4'd1) begin
      v.kind = 2'd1; v.off = {{7{i[11]}}, i[11:3]}; v.func = i[2:0];
    end else begin
      v.kind = 2'd2; v.rs = i[11:9]; v.rt = i[8:6]; v.imm = {{10{i[5]}}, i[5:0]};
    end
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 16'd0; in_pc = 16'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic drive(input vec_t x);
    in_valid = 1'b1; in_instr = x.instr; in_pc = x.pc;
  endtask

  initial begin
    int sent, rcv, cyc, xfer;
    //         instr      pc        kind  op     rd    rs    rt    func  imm        off
    vt[0] = '{16'h074A, 16'h0100, 2'd0, 4'd0,  3'd3, 3'd5, 3'd1, 3'd2, 16'h0000, 16'h0000};
    vt[1] = '{16'h353F, 16'h0102, 2'd2, 4'd3,  3'd0, 3'd2, 3'd4, 3'd0, 16'hFFFF, 16'h0000};
    vt[2] = '{16'h1F85, 16'h0104, 2'd1, 4'd1,  3'd0, 3'd0, 3'd0, 3'd5, 16'h0000, 16'hFFF0};
    vt[3] = '{16'hF000, 16'h0106, 2'd3, 4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vt[4] = '{16'hC123, 16'h0108, 2'd3, 4'd12, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vt[5] = '{16'hBFDF, 16'h010A, 2'd2, 4'd11, 3'd0, 3'd7, 3'd7, 3'd0, 16'h001F, 16'h0000};
    vt[6] = '{16'h1800, 16'h010C, 2'd1, 4'd1,  3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'hFF00};
    vt[7] = '{16'h0FFF, 16'h010E, 2'd0, 4'd0,  3'd7, 3'd7, 3'd7, 3'd7, 16'h0000, 16'h0000};
    vt[8] = '{16'h2A15, 16'h0110, 2'd2, 4'd2,  3'd0, 3'd5, 3'd0, 3'd0, 16'h0015, 16'h0000};

    // Reset state
    do_reset();
    chk("rst.out_valid", 32'(out_valid),    32'd0);
    chk("rst.in_ready",  32'(in_ready),     32'd1);
    chk("rst.count",     32'(decode_count), 32'd0);
    chk("rst.kind",      32'(out_kind),     32'd0);
    chk("rst.instr",     32'(out_instr),    32'd0);
    chk("rst.imm",       32'(out_imm),      32'd0);
    chk("rst.offset",    32'(out_offset),   32'd0);
    chk("rst.pc",        32'(out_pc),       32'd0);

    // Table vectors back to back: each appears the cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) chk_rec($sformatf("vec%0d", i-1), vt[i-1]);
      if (i < NV) drive(vt[i]); else in_valid = 1'b0;
      #1;
      if (i < NV) chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      tick();
    end
    chk("vec.drained", 32'(out_valid),    32'd0);
    chk("vec.count",   32'(decode_count), 32'(NV));

    // Backpressure: OR takes A, SK takes B, C waits, then order A, B, C.
    out_ready = 1'b0;
    drive(vt[0]); #1;
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(vt[1]); #1;
    chk("bp.rdy2", 32'(in_ready), 32'd1);
    chk_rec("bp.hold1", vt[0]);
    tick();
    drive(vt[2]); #1;
    chk("bp.rdy3", 32'(in_ready), 32'd0);
    chk_rec("bp.hold2", vt[0]);
    tick();
    chk("bp.rdy4", 32'(in_ready), 32'd0);
    chk_rec("bp.hold3", vt[0]);
    out_ready = 1'b1;
    tick();
    chk_rec("bp.second", vt[1]);
    chk("bp.rdy5", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_rec("bp.third", vt[2]);
    tick();
    chk("bp.drained", 32'(out_valid),    32'd0);
    chk("bp.count",   32'(decode_count), 32'(NV + 3));

    // Flush with OR and SK full; the transfer in the flush cycle counts.
    do_reset();
    drive(vt[3]);
    tick();
    drive(vt[4]);
    tick();
    chk("fl.full", 32'(in_ready), 32'd0);
    drive(vt[5]); flush = 1'b1; out_ready = 1'b1; #1;
    chk("fl.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl.out_valid", 32'(out_valid),    32'd0);
    chk("fl.sk_empty",  32'(in_ready),     32'd1);
    chk("fl.count",     32'(decode_count), 32'd1);
    tick();
    tick();
    chk("fl.no_ghost", 32'(out_valid),    32'd0);
    chk("fl.count2",   32'(decode_count), 32'd1);

    // Randomized handshakes against a scoreboard.
    do_reset();
    q.delete();
    sent = 0; rcv = 0; cyc = 0;
    while ((sent < 10000 || q.size() > 0) && cyc < 40000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_instr  = 16'($urandom);
      in_pc     = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_rec($sformatf("rnd%0d", rcv), e);
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_instr, in_pc));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd.timeout", 32'(cyc < 40000),    32'd1);
    chk("rnd.received", 32'(rcv),           32'd10000);
    chk("rnd.count",   32'(decode_count),   32'(16'(rcv)));

    // Full-rate stream until 65537 transfers since reset: count wraps to 1.
    xfer = rcv; cyc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (xfer < 65537 && cyc < 70000) begin
      in_instr = 16'($urandom);
      #1;
      if (out_valid) xfer++;
      if (xfer == 65537) in_valid = 1'b0;
      tick();
      cyc++;
    end
    out_ready = 1'b0; in_valid = 1'b0; #1;
    chk("wrap.timeout", 32'(cyc < 70000),   32'd1);
    chk("wrap.count",   32'(decode_count),  32'd1);
    chk("wrap.drained", 32'(out_valid),     32'd0);

    // Reset with OR and SK both full.
    in_valid = 1'b1; in_instr = 16'h353F; in_pc = 16'h0200;
    tick();
    tick();
    chk("mr.full", 32'(in_ready), 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0; #1;
    chk("mr.out_valid", 32'(out_valid),    32'd0);
    chk("mr.count",     32'(decode_count), 32'd0);
    chk("mr.in_ready",  32'(in_ready),     32'd1);
    chk("mr.instr",     32'(out_instr),    32'd0);
    chk("mr.kind",      32'(out_kind),     32'd0);
    out_ready = 1'b1;
    tick();
    chk("mr.no_ghost", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
